// File: rtl/ram_stream_reader_if.sv
// Output beat stream of ram_stream_reader: valid/ready with a last-beat flag.
interface ram_stream_reader_if #(
  parameter int data_width = 8
);
  logic                  m_valid;
  logic [data_width-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Streams `length` consecutive words out of a 1-cycle-latency registered RAM port.
// Optional RAM_STREAM_READER_CHECKSUM_EN adds a running sum of accepted beats.
module ram_stream_reader #(
  parameter int addr_width = 9,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] start_addr,
  input  logic [addr_width:0]   length,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] rdata,
  ram_stream_reader_if.master   m,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [data_width-1:0] checksum
`endif
);

  localparam int cw = addr_width + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [cw-1:0]         remaining_q;
  logic [cw-1:0]         len_q;
  logic [cw-1:0]         beat_q;
  logic                  inflight_q;
  logic [data_width-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  push, pop, issue, accept;
  logic [1:0]            occ_after;

  // Handshake: a beat transfers on a rising edge where m_valid && m_ready;
  // m_valid never drops and m_data/m_last never change while the beat waits.
  assign m.m_valid = (count_q != 2'd0);
  assign m.m_data  = fifo_data_q[rd_ptr_q];
  assign m.m_last  = m.m_valid && fifo_last_q[rd_ptr_q];

  assign pop       = m.m_valid && m.m_ready;
  assign push      = inflight_q;
  assign accept    = (state_q == IDLE) && start;
  assign occ_after = count_q + {1'b0, inflight_q} - {1'b0, pop};
  // raddr is sampled by the RAM this edge; its word lands in the FIFO one edge later
  assign issue     = (state_q == RUN) && (remaining_q != '0) && (occ_after < 2'd2);

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      // zero-length goes through DRAIN so busy is visible for one cycle
      IDLE:  if (start) state_d = (length == '0) ? DRAIN : RUN;
      RUN:   if (remaining_q == '0) state_d = DRAIN;
      DRAIN: if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      raddr       <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        raddr       <= start_addr;
        remaining_q <= length;
        len_q       <= length;
        beat_q      <= '0;
      end
      if (issue) begin
        raddr       <= raddr + addr_width'(1);
        remaining_q <= remaining_q - cw'(1);
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rdata;
        fifo_last_q[wr_ptr_q] <= (beat_q == len_q - cw'(1));
        wr_ptr_q              <= ~wr_ptr_q;
        beat_q                <= beat_q + cw'(1);
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [data_width-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum_q <= '0;
    else if (accept) sum_q <= '0;
    else if (pop)    sum_q <= sum_q + m.m_data;
  end

  assign checksum = sum_q;
`else
`endif

endmodule
